serial_paralelo_rx: RTL

Receive-side serial-to-parallel converter for the two-lane PHY. It takes the MSB-first serial bit stream produced by the transmit serializer and finds byte boundaries using the 0xBC comma idle symbol. After a run of commas it declares link activity, then delivers recovered bytes with a valid flag. Its output feeds the 1:2 demultiplexer that rebuilds lanes 0 and 1.

---
 rtl/serial_paralelo_rx.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_paralelo_rx.sv
// ============================================================================
//  Module   : serial_paralelo_rx
//  Purpose  : MSB-first serial-to-parallel receiver aligned on the comma idle
//             symbol; declares link activity after a run of aligned commas.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_paralelo_rx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strb,
  output logic       active
);

  localparam logic [3:0] c_LOCK = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_sr;
  logic [2:0] r_cnt;
  logic [3:0] r_bc_cnt;

  logic [7:0] w_word;
  logic       w_is_comma;
  logic       w_boundary;
  logic [3:0] w_bc_next;

  // The byte completing at this edge includes the bit being sampled now.
  assign w_word     = {r_sr[6:0], data_in};
  assign w_is_comma = (w_word == COMMA);
  assign w_boundary = (r_cnt == 3'd7);
  assign w_bc_next  = r_bc_cnt + 4'd1;

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      r_state   <= ST_SEARCH;
      r_sr      <= 8'h00;
      r_cnt     <= 3'd0;
      r_bc_cnt  <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_strb <= 1'b0;
      active    <= 1'b0;
    end else begin
      r_sr      <= w_word;
      byte_strb <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_is_comma) begin
            r_state  <= ST_ALIGN;
            r_cnt    <= 3'd0;
            r_bc_cnt <= 4'd1;
          end
        end
        ST_ALIGN: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_comma) begin
              r_bc_cnt <= w_bc_next;
              if (w_bc_next == c_LOCK) begin
                r_state <= ST_ACTIVE;
                active  <= 1'b1;
              end
            end else begin
              // Misaligned run: restart the sliding search on the next edge.
              r_state  <= ST_SEARCH;
              r_bc_cnt <= 4'd0;
              r_cnt    <= 3'd0;
            end
          end
        end
        ST_ACTIVE: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_boundary) begin
            byte_strb <= 1'b1;
            if (w_is_comma) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= w_word;
              valid_out <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_SEARCH;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
